// File: rtl/tt_sel_driver.sv
// -----------------------------------------------------------------------------
// tt_sel_driver
//
// Drives the design-select control pins of the on-chip controller. A request
// carries a target design address. The block then produces this pin sequence:
//   1. drop enable;
//   2. pulse the select counter reset;
//   3. issue `addr` increment pulses;
//   4. restore enable to the requested value.
//
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   req_valid       a select request is presented
//   req_ready       request can be accepted (high only while idle)
//   req_addr        target design address, sampled on accept
//   req_ena         enable value to drive after selection, sampled on accept
//   busy            sequence in progress
//   done            one-cycle pulse when the sequence completes
//   cur_addr        address most recently completed
//   ctrl_sel_rst_n  controller select-reset pad (active low)
//   ctrl_sel_inc    controller select-increment pad
//   ctrl_ena        controller enable pad
// -----------------------------------------------------------------------------
module tt_sel_driver #(
    parameter int ADDR_W   = 10,
    parameter int HALF_PER = 4,
    parameter int RST_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIS,
        S_RST,
        S_REL,
        S_INC_HI,
        S_INC_LO,
        S_EN
    } state_t;

    // The timer is loaded with (length - 1), so it only has to hold the
    // longest phase length minus one.
    localparam int TMAX  = (HALF_PER > RST_CYC) ? HALF_PER : RST_CYC;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0]  HP_LD   = TMR_W'(HALF_PER - 1);
    localparam logic [TMR_W-1:0]  RS_LD   = TMR_W'(RST_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_0   = '0;
    localparam logic [TMR_W-1:0]  TMR_1   = TMR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_0   = '0;
    localparam logic [ADDR_W-1:0] CNT_1   = ADDR_W'(1);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] addr_lat;
    logic              ena_lat;

    assign req_ready = (state == S_IDLE);
    assign busy      = !req_ready;

    // Every output is set on the edge that enters a state. The pins therefore
    // show the new state's values in the first cycle of that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            timer          <= TMR_0;
            cnt            <= CNT_0;
            addr_lat       <= CNT_0;
            ena_lat        <= 1'b0;
            done           <= 1'b0;
            cur_addr       <= CNT_0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Release the select reset held during chip reset; the
                    // controller then sits at address 0, matching cur_addr.
                    ctrl_sel_rst_n <= 1'b1;
                    ctrl_sel_inc   <= 1'b0;
                    if (req_valid) begin
                        cnt      <= req_addr;
                        addr_lat <= req_addr;
                        ena_lat  <= req_ena;
                        ctrl_ena <= 1'b0;
                        timer    <= HP_LD;
                        state    <= S_DIS;
                    end
                end

                S_DIS: begin
                    if (timer != TMR_0) begin
                        timer <= timer - TMR_1;
                    end else begin
                        ctrl_sel_rst_n <= 1'b0;
                        timer          <= RS_LD;
                        state          <= S_RST;
                    end
                end

                S_RST: begin
                    if (timer != TMR_0) begin
                        timer <= timer - TMR_1;
                    end else begin
                        ctrl_sel_rst_n <= 1'b1;
                        timer          <= HP_LD;
                        state          <= S_REL;
                    end
                end

                S_REL: begin
                    if (timer != TMR_0) begin
                        timer <= timer - TMR_1;
                    end else if (cnt != CNT_0) begin
                        ctrl_sel_inc <= 1'b1;
                        timer        <= HP_LD;
                        state        <= S_INC_HI;
                    end else begin
                        ctrl_ena <= ena_lat;
                        done     <= 1'b1;
                        cur_addr <= addr_lat;
                        state    <= S_EN;
                    end
                end

                S_INC_HI: begin
                    if (timer != TMR_0) begin
                        timer <= timer - TMR_1;
                    end else begin
                        ctrl_sel_inc <= 1'b0;
                        timer        <= HP_LD;
                        state        <= S_INC_LO;
                    end
                end

                S_INC_LO: begin
                    if (timer != TMR_0) begin
                        timer <= timer - TMR_1;
                    end else begin
                        cnt <= cnt - CNT_1;
                        // cnt == 1 means this low phase closed the last pulse.
                        if (cnt != CNT_1) begin
                            ctrl_sel_inc <= 1'b1;
                            timer        <= HP_LD;
                            state        <= S_INC_HI;
                        end else begin
                            ctrl_ena <= ena_lat;
                            done     <= 1'b1;
                            cur_addr <= addr_lat;
                            state    <= S_EN;
                        end
                    end
                end

                S_EN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sel_driver.sv
module tb_tt_sel_driver;

    logic       clk;
    logic       rst_n;

    // Default-parameter instance
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_addr;
    logic       req_ena;
    logic       busy;
    logic       done;
    logic [9:0] cur_addr;
    logic       sel_rst_n;
    logic       sel_inc;
    logic       ena;

    // Fast instance: HALF_PER=1, RST_CYC=1
    logic       b_req_valid;
    logic       b_req_ready;
    logic [9:0] b_req_addr;
    logic       b_req_ena;
    logic       b_busy;
    logic       b_done;
    logic [9:0] b_cur_addr;
    logic       b_sel_rst_n;
    logic       b_sel_inc;
    logic       b_ena;

    int n_checks = 0;
    int n_errors = 0;

    tt_sel_driver #(.ADDR_W(10), .HALF_PER(4), .RST_CYC(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_ena        (req_ena),
        .busy           (busy),
        .done           (done),
        .cur_addr       (cur_addr),
        .ctrl_sel_rst_n (sel_rst_n),
        .ctrl_sel_inc   (sel_inc),
        .ctrl_ena       (ena)
    );

    tt_sel_driver #(.ADDR_W(10), .HALF_PER(1), .RST_CYC(1)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (b_req_valid),
        .req_ready      (b_req_ready),
        .req_addr       (b_req_addr),
        .req_ena        (b_req_ena),
        .busy           (b_busy),
        .done           (b_done),
        .cur_addr       (b_cur_addr),
        .ctrl_sel_rst_n (b_sel_rst_n),
        .ctrl_sel_inc   (b_sel_inc),
        .ctrl_ena       (b_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller select-counter model: cleared by select reset, counts rises of inc.
    logic [15:0] model_cnt;
    logic        model_prev;
    always @(posedge clk) begin
        if (!sel_rst_n) begin
            model_cnt  <= 16'd0;
            model_prev <= 1'b0;
        end else begin
            if (sel_inc && !model_prev) model_cnt <= model_cnt + 16'd1;
            model_prev <= sel_inc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one request to the default instance; returns just after the accept edge.
    task automatic do_req(input logic [9:0] a, input logic e);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_ena   = e;
        check("ready_before_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Observe the default instance cycle by cycle (cycle 1 = first after accept)
    // until done, or until the cycle budget runs out (done_cyc stays -1).
    task automatic measure(input int max_cyc, output int done_cyc, output int pulses,
                           output int first_inc, output int bad_runs, output int rst_first,
                           output int rst_last, output int ena_hi, output int overlap);
        int hi_run;
        int lo_run;
        logic prev;
        done_cyc = -1; pulses = 0; first_inc = -1; bad_runs = 0;
        rst_first = -1; rst_last = -1; ena_hi = 0; overlap = 0;
        hi_run = 0; lo_run = 0; prev = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (!sel_rst_n) begin
                if (rst_first < 0) rst_first = k;
                rst_last = k;
            end
            if (!sel_rst_n && sel_inc) overlap++;
            if (ena && !done) ena_hi++;
            if (sel_inc && !prev) begin
                pulses++;
                if (first_inc < 0) first_inc = k;
                if (pulses > 1 && lo_run != 4) bad_runs++;
                hi_run = 1;
            end else if (sel_inc) begin
                hi_run++;
            end else if (prev) begin
                if (hi_run != 4) bad_runs++;
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prev = sel_inc;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    int dc, np, fi, br, rf, rl, eh, ov;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_ena = 1'b0;

        // ---- Reset then idle
        repeat (3) @(negedge clk);
        check("rst_sel_rst_n", sel_rst_n, 0);
        check("rst_inc", sel_inc, 0);
        check("rst_ena", ena, 0);
        check("rst_done", done, 0);
        check("rst_cur_addr", cur_addr, 0);
        check("rst_b_sel_rst_n", b_sel_rst_n, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", req_ready, 1);
        check("rel_sel_rst_n_still_low", sel_rst_n, 0);
        @(negedge clk);
        check("rel_sel_rst_n_high", sel_rst_n, 1);
        check("rel_busy", busy, 0);

        // ---- addr=0, req_ena=1
        do_req(10'd0, 1'b1);
        measure(200, dc, np, fi, br, rf, rl, eh, ov);
        check("a0_done_cyc", dc, 17);
        check("a0_pulses", np, 0);
        check("a0_rst_first", rf, 5);
        check("a0_rst_last", rl, 12);
        check("a0_ena_early", eh, 0);
        check("a0_ena_at_done", ena, 1);
        check("a0_cur_addr", cur_addr, 0);
        check("a0_model", model_cnt, 0);
        @(negedge clk);
        check("a0_done_pulse_len", done, 0);
        check("a0_ready_after", req_ready, 1);

        // ---- addr=3, req_ena=1
        do_req(10'd3, 1'b1);
        #1;
        check("a3_busy", busy, 1);
        check("a3_ready_low", req_ready, 0);
        measure(200, dc, np, fi, br, rf, rl, eh, ov);
        check("a3_done_cyc", dc, 41);
        check("a3_pulses", np, 3);
        check("a3_first_inc", fi, 17);
        check("a3_bad_runs", br, 0);
        check("a3_overlap", ov, 0);
        check("a3_ena_early", eh, 0);
        check("a3_cur_addr", cur_addr, 3);
        check("a3_model", model_cnt, 3);

        // ---- addr=5 ena=0 with req_valid held, then addr=2 ena=1
        @(negedge clk);
        req_valid = 1'b1; req_addr = 10'd5; req_ena = 1'b0;
        @(posedge clk);
        #1;
        req_addr = 10'd2; req_ena = 1'b1;
        measure(200, dc, np, fi, br, rf, rl, eh, ov);
        check("b2b1_done_cyc", dc, 57);
        check("b2b1_pulses", np, 5);
        check("b2b1_bad_runs", br, 0);
        check("b2b1_cur_addr", cur_addr, 5);
        check("b2b1_ena", ena, 0);
        check("b2b1_model", model_cnt, 5);
        @(negedge clk);
        check("b2b_ready_after_done", req_ready, 1);
        check("b2b_ena_stays_low", ena, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        measure(200, dc, np, fi, br, rf, rl, eh, ov);
        check("b2b2_done_cyc", dc, 33);
        check("b2b2_pulses", np, 2);
        check("b2b2_cur_addr", cur_addr, 2);
        check("b2b2_ena", ena, 1);
        check("b2b2_model", model_cnt, 2);

        // ---- reset during 2nd inc high phase of addr=7
        do_req(10'd7, 1'b1);
        repeat (26) @(negedge clk);
        check("ar_in_2nd_high", sel_inc, 1);
        rst_n = 1'b0;
        #1;
        check("ar_sel_rst_n", sel_rst_n, 0);
        check("ar_inc", sel_inc, 0);
        check("ar_ena", ena, 0);
        check("ar_done", done, 0);
        check("ar_cur_addr", cur_addr, 0);
        check("ar_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (done) seen++;
            end
            check("ar_no_done", seen, 0);
        end
        check("ar_sel_rst_n_rel", sel_rst_n, 1);
        do_req(10'd1, 1'b1);
        measure(200, dc, np, fi, br, rf, rl, eh, ov);
        check("ar1_done_cyc", dc, 25);
        check("ar1_pulses", np, 1);
        check("ar1_cur_addr", cur_addr, 1);
        check("ar1_model", model_cnt, 1);

        // ---- fast instance, addr=1023
        @(negedge clk);
        b_req_valid = 1'b1; b_req_addr = 10'h3FF; b_req_ena = 1'b1;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        begin
            int bdc, bp, bbad, hrun;
            logic bprev;
            bdc = -1; bp = 0; bbad = 0; hrun = 0; bprev = 1'b0;
            for (int k = 1; k <= 3000; k++) begin
                @(negedge clk);
                if (b_sel_inc && !bprev) begin
                    bp++;
                    hrun = 1;
                end else if (b_sel_inc) begin
                    hrun++;
                end else if (bprev && hrun != 1) begin
                    bbad++;
                end
                if (b_sel_inc && !b_sel_rst_n) bbad++;
                bprev = b_sel_inc;
                if (b_done) begin
                    bdc = k;
                    break;
                end
            end
            check("fast_done_cyc", bdc, 2050);
            check("fast_pulses", bp, 1023);
            check("fast_bad", bbad, 0);
            check("fast_cur_addr", b_cur_addr, 1023);
            check("fast_ena", b_ena, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_sel_driver.md
# tt_sel_driver

Initiator for the chip's design-select control pins. Given a target design address, it generates the `ctrl_sel_rst_n` / `ctrl_sel_inc` / `ctrl_ena` pulse sequence that the on-chip controller samples from the control-high pads:

- deassert enable;
- reset the select counter;
- pulse increment `addr` times;
- re-enable.

It is used in the demo-board/FPGA-side harness and in the system bench as the driving counterpart of the controller.

## Interface

Parameters:
- `ADDR_W`, 10: width of the design address (number of increment pulses, max 2^ADDR_W-1).
- `HALF_PER`, 4: cycles per high phase and per low phase of each `ctrl_sel_inc` pulse. Also the length of the disable phase and of the reset-release phase. Must be ≥1.
- `RST_CYC`, 8: cycles `ctrl_sel_rst_n` is held low. Must be ≥1.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a select request is presented.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_addr`  in  ADDR_W  target design address; sampled on accept.
- `req_ena`  in  1  value of `ctrl_ena` to drive after selection; sampled on accept.
- `busy`  out  1  sequence in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when the sequence completes.
- `cur_addr`  out  ADDR_W  address most recently completed.
- `ctrl_sel_rst_n`  out  1  to the controller select-reset pad.
- `ctrl_sel_inc`  out  1  to the controller select-increment pad.
- `ctrl_ena`  out  1  to the controller enable pad.

## Operation

- All `ctrl_*`, `done` and `cur_addr` outputs are registered.
- `req_ready = (state == IDLE)`; `busy = !req_ready`.
- Reset values:
  - `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0;
  - `done`=0, `cur_addr`=0;
  - state IDLE, timer 0, increment counter 0.
- The first clock after reset release drives `ctrl_sel_rst_n` to 1. This leaves the controller at address 0, consistent with `cur_addr`=0.
- Accept occurs on a rising edge with `req_valid && req_ready`. On accept, latch `req_addr` into the increment counter, latch `req_ena` and `req_addr`, and enter DIS.
- States, with a down-counting timer loaded on each entry:
  - IDLE: `sel_rst_n`=1, `inc`=0, `ena` holds its last value.
  - DIS (HALF_PER cycles): `ena`=0. Next state RST.
  - RST (RST_CYC cycles): `sel_rst_n`=0. Next state REL.
  - REL (HALF_PER cycles): `sel_rst_n`=1. Next state INC_HI if counter≠0, else EN.
  - INC_HI (HALF_PER cycles): `inc`=1. Next state INC_LO.
  - INC_LO (HALF_PER cycles): `inc`=0. Decrement the counter on exit. Next state INC_HI if counter≠0 after decrement, else EN.
  - EN (1 cycle): `ena`=latched `req_ena`, `done`=1, `cur_addr`=latched address. Next state IDLE.
- `ctrl_sel_rst_n` and `ctrl_sel_inc` are never both active in the same cycle. `ctrl_ena` is 0 throughout DIS to INC_LO.
- Requests presented while busy are ignored, not queued. `req_valid` may stay high; a new request is accepted on the first IDLE cycle after `done`.
- `req_addr` = 0 skips INC_HI/INC_LO entirely.
- `req_addr` = all-ones produces 2^ADDR_W-1 pulses. There is no wrap.

## Timing

- Latency: with accept at edge 0, DIS outputs are visible from cycle 1. `done` is high in cycle 1 + 2·HALF_PER + RST_CYC + 2·HALF_PER·addr.
  - Defaults, addr=0: cycle 17.
  - Defaults, addr=3: cycle 41.
- Back-to-back: `req_ready` is high the cycle after `done`. Minimum spacing between accepts is the latency + 1.
- `ctrl_sel_inc` pulse: exactly HALF_PER cycles high followed by HALF_PER cycles low, for every pulse.
- Asynchronous reset mid-sequence:
  - all outputs take their reset values immediately;
  - the sequence is abandoned;
  - `cur_addr` returns to 0;
  - no `done` is emitted.

## Test plan

- Reset then idle: hold `rst_n`=0 -> `ctrl_sel_rst_n`=0, `ena`=0, `inc`=0, `req_ready` high after release. One cycle after release, `ctrl_sel_rst_n`=1.
- addr=0, `req_ena`=1, defaults -> `ena`=0 for cycles 1–4, `sel_rst_n`=0 for cycles 5–12, no `inc` pulses, `done`+`ena`=1 at cycle 17, `cur_addr`=0.
- addr=3, `req_ena`=1 -> exactly 3 `inc` pulses, each 4 high / 4 low, starting at cycle 17. `done` at cycle 41, `cur_addr`=3. A bench model of the controller counter reads 3.
- addr=5, `req_ena`=0 with `req_valid` held high, followed immediately by addr=2 -> second request accepted the cycle after the first `done`. `ena` stays 0 after the first request. `cur_addr` ends at 2.
- Reset asserted during the 2nd `inc` high phase of addr=7 -> all outputs drop to reset values within the same cycle, no `done`, `cur_addr`=0. The next request (addr=1) completes normally.
- `HALF_PER`=1, `RST_CYC`=1, addr=1023 -> 1023 single-cycle pulses, `done` at cycle 1+2+1+2046=2050.
